// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller: FSM state encoding,
// segment bit positions and the hex-to-segment lookup table (active-high, bits 6:0).
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment pattern (segments a..g, active-high).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display scanner with per-digit blanking gaps and a
// double-buffered update path that only swaps data at frame boundaries.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_OFF   | scanning disabled, outputs inactive, pending data applies
//  ST_BLANK | anti-ghost gap before digit idx, outputs inactive
//  ST_DRIVE | digit idx selected, segments show its decoded nibble
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_CYC   = 1000,
    parameter int BLANK_CYC  = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  load_i,
    output logic                  ready_o,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blank_i,
    output logic [7:0]            seg_o,
    output logic [DIGITS-1:0]     dig_o,
    output logic                  frame_o
);

    localparam int CNT_MAX = (SCAN_CYC > BLANK_CYC) ? SCAN_CYC : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]  BLANK_LD = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0]  SCAN_LD  = CNT_W'(SCAN_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF  = {8{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{ACTIVE_LOW}};

    scan_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wrap;

    logic [4*DIGITS-1:0]  act_data_q, act_data_d, sh_data_q;
    logic [DIGITS-1:0]    act_dp_q, act_dp_d, sh_dp_q;
    logic [DIGITS-1:0]    act_blank_q, act_blank_d, sh_blank_q;
    logic                 pending_q;
    logic                 apply;

    logic [3:0]           nib_sel;
    logic [6:0]           seg_dec;
    logic [7:0]           seg_d;
    logic [DIGITS-1:0]    dig_d;

    // Timers count down from length-1 and advance on terminal count zero.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        if (!en_i) begin
            state_d = ST_OFF;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_BLANK;
                    idx_d   = '0;
                    cnt_d   = BLANK_LD;
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DRIVE;
                        cnt_d   = SCAN_LD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_BLANK;
                        cnt_d   = BLANK_LD;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= en_i ? ST_BLANK : ST_OFF;
            idx_q   <= '0;
            cnt_q   <= en_i ? BLANK_LD : '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Swapping only at the frame wrap or while dark keeps every frame coherent.
    assign apply = pending_q && (wrap || (state_d == ST_OFF));

    always_comb begin
        act_data_d  = apply ? sh_data_q  : act_data_q;
        act_dp_d    = apply ? sh_dp_q    : act_dp_q;
        act_blank_d = apply ? sh_blank_q : act_blank_q;
        nib_sel     = act_data_d[{idx_d, 2'b00} +: 4];
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nib_sel),
        .seg    (seg_dec)
    );

    // Outputs are built from next-state values so the registers line up with state_q.
    always_comb begin
        seg_d = 8'h00;
        dig_d = '0;
        if (state_d == ST_DRIVE) begin
            dig_d[idx_d] = 1'b1;
            if (!act_blank_d[idx_d]) begin
                seg_d[6:0]    = seg_dec;
                seg_d[SEG_DP] = act_dp_d[idx_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '1;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '1;
            pending_q   <= 1'b0;
            seg_o       <= SEG_OFF;
            dig_o       <= DIG_OFF;
            frame_o     <= 1'b0;
        end else begin
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            if (apply) begin
                pending_q <= 1'b0;
            end else if (load_i && !pending_q) begin
                sh_data_q  <= data_i;
                sh_dp_q    <= dp_i;
                sh_blank_q <= blank_i;
                pending_q  <= 1'b1;
            end
            seg_o   <= seg_d ^ SEG_OFF;
            dig_o   <= dig_d ^ DIG_OFF;
            frame_o <= apply;
        end
    end

    assign ready_o = !pending_q;

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 Parameter SCAN_CYC, default 1000: drive cycles per digit, >=1.
REQ-003 Parameter BLANK_CYC, default 8: anti-ghost blanking cycles before each digit, >=1.
REQ-004 Parameter ACTIVE_LOW, default 0: 1 inverts seg_o and dig_o polarity.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 en_i  in  1  scan enable; low forces OFF state.
REQ-008 load_i  in  1  update request; qualifies data_i/dp_i/blank_i.
REQ-009 ready_o  out  1  update accepted when load_i && ready_o.
REQ-010 data_i  in  4*DIGITS  hex nibble per digit, digit k at [4k+3:4k].
REQ-011 dp_i  in  DIGITS  decimal point per digit.
REQ-012 blank_i  in  DIGITS  per-digit blank; blanked digit shows all segments off, dp included.
REQ-013 seg_o  out  8  segments, bit0=a(top), 1=b, 2=c, 3=d, 4=e, 5=f, 6=g(middle), 7=dp.
REQ-014 dig_o  out  DIGITS  digit select, one-hot while driving.
REQ-015 frame_o  out  1  one-cycle pulse when a new update is applied.

Function
REQ-016 States OFF, BLANK, DRIVE; cycle counter cnt; digit index idx.
REQ-017 BLANK: seg_o and dig_o inactive for exactly BLANK_CYC cycles, then DRIVE, cnt=0.
REQ-018 DRIVE: dig_o[idx] active, others inactive; seg_o = decode(active nibble idx) with bit7=dp, or all-off if blank bit set; lasts exactly SCAN_CYC cycles.
REQ-019 DRIVE end: idx increments, DIGITS-1 wraps to 0; next state BLANK, cnt=0.
REQ-020 Frame period SHALL be DIGITS*(BLANK_CYC+SCAN_CYC) cycles, no gaps.
REQ-021 Outputs SHALL be registered; seg_o/dig_o change only on state/idx transitions.
REQ-022 Decode: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (bits 6:0, active-high form).
REQ-023 Double buffering: load_i && ready_o captures inputs into shadow registers, sets pending; ready_o = !pending.
REQ-024 load_i while ready_o low SHALL be ignored; requester holds load_i.
REQ-025 Apply: on the DRIVE(idx=DIGITS-1)->BLANK(idx=0) transition, if pending, active<=shadow, pending<=0, frame_o=1 that cycle.
REQ-026 Active registers SHALL never change mid-frame; no torn digits.
REQ-027 en_i low: next cycle state OFF, idx=0, cnt=0, outputs inactive; pending applied in the first OFF cycle with frame_o pulse.
REQ-028 en_i high from OFF: enter BLANK idx=0, cnt=0.
REQ-029 ACTIVE_LOW=1: seg_o and dig_o inverted at output register only; inactive = all ones.

Reset
REQ-030 rst_i high: state BLANK if en_i else OFF, idx=0, cnt=0, active/shadow data 0, dp 0, blank all-ones, pending 0.
REQ-031 Reset outputs: seg_o and dig_o inactive, ready_o=1, frame_o=0.
REQ-032 Reset mid-update discards shadow; reset dominates load_i and en_i same cycle.

Structure
REQ-033 Package seg7_pkg SHALL hold state enum, segment bit-index constants, hex-to-segment decode table.
REQ-034 Sub-module seg7_hex_decode: combinational nibble->7 segments, used once on selected digit.

Verification
REQ-035 DIGITS=4, SCAN_CYC=4, BLANK_CYC=2, en_i=1, reset release -> 2 blank cycles, dig_o=0001 4 cycles; frame 24 cycles.
REQ-036 Load data_i=16'h4321, dp_i=0, blank_i=0 -> frame_o at next wrap; next frame seg_o 06,5B,4F,66 on digits 0..3.
REQ-037 Second load while ready_o=0 with 16'hFFFF -> ignored; display stays 4321; ready_o returns 1 with frame_o.
REQ-038 blank_i=4'b0100, dp_i=4'b0001 -> digit2 seg_o=00, digit0 seg_o=86.
REQ-039 en_i low mid-DRIVE with pending load -> outputs inactive next cycle, frame_o pulse first OFF cycle; en_i high restarts at digit 0 after blanking.
REQ-040 ACTIVE_LOW=1, digit value 8 -> seg_o=80 on 8h'7F pattern inverted, dig_o=1110 for digit0, all ones during BLANK.
